// File: rtl/pipe_bundle_reg.sv
// Purpose  : elastic pipeline register for a LANES-wide instruction bundle, with a 2-entry skid buffer.
// Latency  : 1 cycle from an accepted bundle to out_valid. Sustains 1 bundle/cycle while out_ready stays high.
// Backpres.: in_ready is decoded from registered state only (low when both entries are full); no comb path from out_ready.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   flush                 synchronous discard-all. It has the highest priority and leaves the block empty.
//   in_valid/in_ready     per-lane valid of the offered bundle, and the bundle-level ready
//   in_ctrl/in_data       lane i at [i*CTRL_W +: CTRL_W] / [i*DATA_W +: DATA_W]
//   out_valid/out_ready   per-lane valid of the head bundle, and the bundle-level downstream accept
//   out_ctrl/out_data     head bundle contents
//   occupancy             number of bundles held (0..2)
// Optional: define PIPE_BUNDLE_PERF_CNT_EN to add the saturating stall_cnt and flush_cnt outputs.
module pipe_bundle_reg #(
    parameter int LANES  = 2,
    parameter int CTRL_W = 15,
    parameter int DATA_W = 143
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [LANES-1:0]         in_valid,
    output logic                     in_ready,
    input  logic [LANES*CTRL_W-1:0]  in_ctrl,
    input  logic [LANES*DATA_W-1:0]  in_data,
    output logic [LANES-1:0]         out_valid,
    input  logic                     out_ready,
    output logic [LANES*CTRL_W-1:0]  out_ctrl,
    output logic [LANES*DATA_W-1:0]  out_data,
    output logic [1:0]               occupancy
`ifdef PIPE_BUNDLE_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt
`endif
);

    typedef struct packed {
        logic [LANES-1:0]        vld;
        logic [LANES*CTRL_W-1:0] ctrl;
        logic [LANES*DATA_W-1:0] data;
    } bundle_t;

    // The encoding equals the number of bundles held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t  state_q, state_d;
    bundle_t main_q, main_d;   // head entry; drives the outputs directly
    bundle_t skid_q, skid_d;   // second entry; filled only while the head is stalled
    bundle_t in_bundle;

    logic push;
    logic pop;

    // A lane that is not valid is captured as a bubble: its control field is forced to
    // zero so downstream stages see a no-op. Its data is captured as-is.
    always_comb begin
        in_bundle.vld  = in_valid;
        in_bundle.data = in_data;
        in_bundle.ctrl = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_valid[i]) begin
                in_bundle.ctrl[i*CTRL_W +: CTRL_W] = in_ctrl[i*CTRL_W +: CTRL_W];
            end
        end
    end

    assign in_ready = (state_q != ST_TWO);
    assign push     = (|in_valid) && in_ready && !flush;
    assign pop      = (|main_q.vld) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Drop everything, including any bundle offered this cycle. The head data
            // is left stale because it is meaningless once out_valid is low.
            state_d     = ST_EMPTY;
            main_d.vld  = '0;
            main_d.ctrl = '0;
            skid_d.vld  = '0;
            skid_d.ctrl = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_d  = in_bundle;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = in_bundle;
                    end else if (push) begin
                        skid_d  = in_bundle;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        main_d.vld  = '0;
                        main_d.ctrl = '0;
                        state_d     = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can occur.
                    if (pop) begin
                        main_d      = skid_q;
                        skid_d.vld  = '0;
                        skid_d.ctrl = '0;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_valid = main_q.vld;
    assign out_ctrl  = main_q.ctrl;
    assign out_data  = main_q.data;

    always_comb begin
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

`ifdef PIPE_BUNDLE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate rather than wrap, so a long run never reads as a short one.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((|main_q.vld) && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        // Count only flushes that actually discard something (held or offered).
        if (flush && ((state_q != ST_EMPTY) || (|in_valid)) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_bundle_reg.sv
// Purpose  : self-checking bench for pipe_bundle_reg against a queue-based reference model.
// Latency  : the model is advanced once per clock; outputs are compared 1 time unit after each rising edge.
// Backpres.: out_ready is driven with directed and randomized patterns; flush is randomized sparsely.
module tb_pipe_bundle_reg;

    localparam int L   = 2;
    localparam int CW  = 15;
    localparam int DW  = 143;
    localparam int CTW = L*CW;
    localparam int DTW = L*DW;

    typedef struct {
        logic [L-1:0]   vld;
        logic [CTW-1:0] ctrl;
        logic [DTW-1:0] data;
    } ent_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           flush;
    logic [L-1:0]   in_valid;
    logic           in_ready;
    logic [CTW-1:0] in_ctrl;
    logic [DTW-1:0] in_data;
    logic [L-1:0]   out_valid;
    logic           out_ready;
    logic [CTW-1:0] out_ctrl;
    logic [DTW-1:0] out_data;
    logic [1:0]     occupancy;
`ifdef PIPE_BUNDLE_PERF_CNT_EN
    logic [31:0]    stall_cnt;
    logic [31:0]    flush_cnt;
`endif

    // Reference model: an ordered list of held bundles, with at most two entries.
    ent_t        q[$];
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    pipe_bundle_reg #(.LANES(L), .CTRL_W(CW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_BUNDLE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_occ"},      512'(occupancy), 512'(q.size()));
        chk({tag, "_in_ready"}, 512'(in_ready),  512'(q.size() < 2));
        if (q.size() > 0) begin
            chk({tag, "_out_valid"}, 512'(out_valid), 512'(q[0].vld));
            chk({tag, "_out_ctrl"},  512'(out_ctrl),  512'(q[0].ctrl));
            chk({tag, "_out_data"},  512'(out_data),  512'(q[0].data));
        end else begin
            chk({tag, "_out_valid"}, 512'(out_valid), 512'(0));
            chk({tag, "_out_ctrl"},  512'(out_ctrl),  512'(0));
        end
`ifdef PIPE_BUNDLE_PERF_CNT_EN
        chk({tag, "_stall_cnt"}, 512'(stall_cnt), 512'(m_stall));
        chk({tag, "_flush_cnt"}, 512'(flush_cnt), 512'(m_flush));
`endif
    endtask

    // Apply the current inputs for one clock, update the model, and compare.
    task automatic cycle(input string tag);
        ent_t b;
        bit   do_pop;
        bit   do_push;
        do_pop  = (q.size() > 0) && out_ready;
        do_push = (|in_valid) && (q.size() < 2) && !flush;
        b.vld   = in_valid;
        b.data  = in_data;
        b.ctrl  = '0;
        for (int i = 0; i < L; i++) begin
            if (in_valid[i]) b.ctrl[i*CW +: CW] = in_ctrl[i*CW +: CW];
        end
        if ((q.size() > 0) && !out_ready) m_stall++;
        if (flush && ((q.size() > 0) || (|in_valid))) m_flush++;
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(b);
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic rand_payload();
        for (int i = 0; i < CTW; i++) in_ctrl[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < DTW; i++) in_data[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic model_reset();
        q.delete();
        m_stall = 0;
        m_flush = 0;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = '0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_outs("reset");
        chk("reset_out_data", 512'(out_data), 512'(0));
        reset_n = 1'b1;

        // Stream: back-to-back full bundles with the sink always ready.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 2'b11;
            rand_payload();
            cycle("t1");
            chk("t1_occ_le1", 512'(occupancy <= 2'd1), 512'(1));
        end
        in_valid = '0;
        cycle("t1_drain");

        // Backpressure: fill both entries, hold C at the input, then drain.
        out_ready = 1'b0;
        in_valid  = 2'b11; rand_payload(); cycle("t2_a");
        in_valid  = 2'b11; rand_payload(); cycle("t2_b");
        chk("t2_full_occ", 512'(occupancy), 512'(2));
        chk("t2_full_rdy", 512'(in_ready), 512'(0));
        in_valid  = 2'b11; rand_payload(); cycle("t2_c_held");
        out_ready = 1'b1;
        cycle("t2_pop_a");
        cycle("t2_pop_b");
        in_valid  = '0;
        cycle("t2_pop_c");
        cycle("t2_empty");

        // Lane bubble: lane 0 is invalid, so its control field must read zero.
        out_ready = 1'b0;
        in_valid  = 2'b10;
        rand_payload();
        in_ctrl   = {15'h1234, 15'h7FFF};
        cycle("t3");
        chk("t3_vld",   512'(out_valid), 512'(2'b10));
        chk("t3_ctrl0", 512'(out_ctrl[CW-1:0]), 512'(0));
        chk("t3_ctrl1", 512'(out_ctrl[2*CW-1:CW]), 512'(15'h1234));
        in_valid  = '0;
        out_ready = 1'b1;
        cycle("t3_drain");

        // Flush while full, with a bundle offered in the same cycle.
        out_ready = 1'b0;
        in_valid  = 2'b11; rand_payload(); cycle("t4_a");
        in_valid  = 2'b11; rand_payload(); cycle("t4_b");
        in_valid  = 2'b11; rand_payload();
        flush     = 1'b1;
        cycle("t4_flush");
        chk("t4_occ",   512'(occupancy), 512'(0));
        chk("t4_vld",   512'(out_valid), 512'(0));
        chk("t4_ctrl",  512'(out_ctrl),  512'(0));
        chk("t4_ready", 512'(in_ready),  512'(1));
        flush     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b1;
        cycle("t4_after1");
        cycle("t4_after2");

`ifdef PIPE_BUNDLE_PERF_CNT_EN
        begin
            int unsigned s0;
            int unsigned f0;
            out_ready = 1'b0;
            in_valid  = 2'b11; rand_payload(); cycle("t6_push");
            in_valid  = '0;
            s0 = m_stall;
            f0 = m_flush;
            for (int k = 0; k < 5; k++) cycle("t6_stall");
            flush     = 1'b1;
            out_ready = 1'b1;
            cycle("t6_flush");
            flush     = 1'b0;
            chk("t6_stall_total", 512'(stall_cnt), 512'(s0 + 5));
            chk("t6_flush_total", 512'(flush_cnt), 512'(f0 + 1));
        end
`endif

        // Randomized traffic with a varying sink duty cycle and sparse flushes.
        for (int k = 0; k < 600; k++) begin
            in_valid  = 2'($urandom_range(0, 3));
            rand_payload();
            flush     = ($urandom_range(0, 15) == 0);
            case ((k / 150) % 4)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = ($urandom_range(0, 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cycle("rnd");
        end
        flush    = 1'b0;
        in_valid = '0;

        // Async reset between edges while full; outputs must clear before the next edge.
        out_ready = 1'b0;
        in_valid  = 2'b11; rand_payload(); cycle("t5_a");
        in_valid  = 2'b11; rand_payload(); cycle("t5_b");
        in_valid  = '0;
        chk("t5_full", 512'(occupancy), 512'(2));
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outs("t5_async");
        chk("t5_out_data", 512'(out_data), 512'(0));
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        in_valid  = 2'b11;
        rand_payload();
        cycle("t5_e");
        in_valid  = '0;
        cycle("t5_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pipe_bundle_reg.md
Name: pipe_bundle_reg

Overview:
Parametrised elastic inter-stage pipeline register carrying a superscalar bundle of LANES instructions. Each lane has a control field (exe/mem/wb) and a data field (reg specifiers, operands, immediates). It replaces fixed stall/clear stage registers with a valid/ready handshake and a 2-entry skid buffer. Flush inserts bubbles. The block sits between any two pipeline stages (ID/EXE, EXE/MEM, ...).

Parameters:
LANES, 2, number of instruction lanes per bundle (>=1)
CTRL_W, 15, control bits per lane (9 exe + 4 mem + 2 wb)
DATA_W, 143, data bits per lane (3x5 reg specifiers + 4x32 operands/immediates)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous bubble insert / discard-all
in_valid  in  LANES  per-lane valid of the incoming bundle
in_ready  out  1  stage can accept a bundle
in_ctrl  in  LANES*CTRL_W  lane i at [i*CTRL_W +: CTRL_W]
in_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
out_valid  out  LANES  per-lane valid of the head bundle
out_ready  in  1  downstream accepts head bundle
out_ctrl  out  LANES*CTRL_W  head bundle control
out_data  out  LANES*DATA_W  head bundle data
occupancy  out  2  bundles held (0..2)

Behaviour:
- Reset (reset_n low, async): state EMPTY; out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1. Applies immediately, including mid-operation in any state.
- Bundle push = |in_valid & in_ready & ~flush. Bundle pop = |out_valid & out_ready.
- Lanes move as one bundle; no per-lane partial transfer.
- On capture, any lane with in_valid=0 stores ctrl=0, which is a bubble. Data for that lane is captured as-is.
- in_ready = (state != TWO). It is decoded from registered state only, with no combinational path from out_ready.
- Storage: main register (drives outputs) plus skid register.
- FSM:
  - EMPTY: push -> ONE (main<=in).
  - ONE: push&pop -> ONE (main<=in); push only -> TWO (skid<=in); pop only -> EMPTY; neither -> hold.
  - TWO: pop -> ONE (main<=skid); else hold. Push impossible because in_ready=0.
- occupancy: EMPTY=0, ONE=1, TWO=2.
- Latency: 1 cycle from push in EMPTY (or ONE with pop) to out_valid. Sustained throughput is 1 bundle/cycle with out_ready high.
- Ordering: strict FIFO; no loss or duplication under any out_ready pattern.
- Flush has highest priority:
  - Next state is EMPTY; out_valid=0, out_ctrl=0, skid invalidated. out_data holds its previous value (don't care).
  - A bundle offered during the flush cycle is discarded even if in_ready=1.
  - A pop coinciding with flush still counts as consumed by downstream.
- When holding (no pop), outputs are stable.
- When EMPTY, out_ctrl=0 and out_valid=0.

Optional Feature:
PIPE_BUNDLE_PERF_CNT_EN
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle |out_valid & ~out_ready.
  - flush_cnt increments each flush cycle where occupancy!=0 or a bundle was offered.
  - Both counters saturate at 32'hFFFFFFFF and are cleared only by reset_n (reset value 0).
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Stream: out_ready=1, push bundles A,B,C,D back-to-back with in_valid=2'b11 -> each appears on outputs exactly 1 cycle after push; in_ready stays 1; occupancy stays ≤1.
2. Backpressure: out_ready=0, push A then B -> occupancy=2, in_ready=0, C held at input. Raise out_ready -> outputs A,B,C in consecutive pops, none lost or duplicated.
3. Lane bubble: in_valid=2'b10, lane0 ctrl=15'h7FFF, lane1 ctrl=15'h1234 -> out_valid=2'b10, lane0 out_ctrl=0, lane1 out_ctrl=15'h1234.
4. Flush in TWO with in_valid=2'b11 offered -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1; offered bundle never appears.
5. Async reset mid-operation: reset_n low between edges while in TWO -> outputs zero and in_ready=1 before the next clock edge; after release, push E -> E out 1 cycle later.
6. With PIPE_BUNDLE_PERF_CNT_EN: hold valid head with out_ready=0 for 5 cycles, then flush once -> stall_cnt=5, flush_cnt=1.
